// File: rtl/bf16_to_int_seq.sv
// Multi-cycle bfloat16 -> INT_W integer converter (RNE/RTZ, saturating, NV/NX flags) over valid/ready.
// Define BF16_CVT_FAST_SHIFT_EN for a single-cycle barrel shift; default is a serial one-bit shifter.
module bf16_to_int_seq #(
  parameter int unsigned INT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [15:0]      op_a_i,
  input  logic             signed_i,
  input  logic             rtz_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [INT_W-1:0] result_o,
  output logic [1:0]       flags_o
);

  localparam int unsigned MAG_W = INT_W + 1;
  localparam int unsigned CNT_W = 5;
  // Biased exponents: e = -1, e = 7 (mantissa already integer-aligned), e = INT_W (overflow)
  localparam logic [7:0] EXP_MIN = 8'd126;
  localparam logic [7:0] EXP_E7  = 8'd134;
  localparam logic [7:0] EXP_SAT = 8'(127 + INT_W);

  localparam logic [INT_W-1:0] SMAX = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] SMIN = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic [INT_W-1:0] UMAX = {INT_W{1'b1}};
  localparam logic [MAG_W-1:0] LIM_POS = {2'b00, {(INT_W-1){1'b1}}};
  localparam logic [MAG_W-1:0] LIM_NEG = {2'b01, {(INT_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_ROUND, S_DONE} state_t;

  state_t             r_state;
  logic [MAG_W-1:0]   r_mag;
  logic               r_g;
  logic               r_s;
  logic               r_sign;
  logic               r_signed;
  logic               r_rtz;
  logic               r_left;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [INT_W-1:0]   r_result;
  logic [1:0]         r_flags;

  logic               w_sign;
  logic [7:0]         w_exp;
  logic [6:0]         w_frac;
  logic [7:0]         w_mant;
  logic               w_is_nan;
  logic               w_inc;
  logic               w_nx;
  logic [MAG_W-1:0]   w_rmag;
  logic [INT_W-1:0]   w_neg;
  logic [INT_W-1:0]   w_rnd_res;
  logic [1:0]         w_rnd_flg;

  assign w_sign   = op_a_i[15];
  assign w_exp    = op_a_i[14:7];
  assign w_frac   = op_a_i[6:0];
  assign w_mant   = {1'b1, w_frac};
  assign w_is_nan = (w_exp == 8'hFF) && (w_frac != 7'd0);

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign result_o    = r_result;
  assign flags_o     = r_flags;

  // Rounding increment and two's-complement of the rounded magnitude
  assign w_inc  = ~r_rtz & r_g & (r_s | r_mag[0]);
  assign w_nx   = r_g | r_s;
  assign w_rmag = r_mag + MAG_W'(w_inc);
  assign w_neg  = INT_W'(0) - w_rmag[INT_W-1:0];

  // Range check of the rounded magnitude against the destination format
  always_comb begin
    w_rnd_res = r_sign ? w_neg : w_rmag[INT_W-1:0];
    w_rnd_flg = {1'b0, w_nx};
    if (r_signed) begin
      if (!r_sign && (w_rmag > LIM_POS)) begin
        w_rnd_res = SMAX;
        w_rnd_flg = 2'b10;
      end else if (r_sign && (w_rmag > LIM_NEG)) begin
        w_rnd_res = SMIN;
        w_rnd_flg = 2'b10;
      end
    end else begin
      if (!r_sign && w_rmag[INT_W]) begin
        w_rnd_res = UMAX;
        w_rnd_flg = 2'b10;
      end else if (r_sign && (w_rmag != MAG_W'(0))) begin
        w_rnd_res = '0;
        w_rnd_flg = 2'b10;
      end
    end
  end

`ifdef BF16_CVT_FAST_SHIFT_EN
  logic [15:0] w_ext;
  // Right shift of the 8-bit mantissa; low byte holds the shifted-out bits for guard/sticky
  assign w_ext = {r_mag[7:0], 8'h00} >> r_cnt;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_mag       <= '0;
      r_g         <= 1'b0;
      r_s         <= 1'b0;
      r_sign      <= 1'b0;
      r_signed    <= 1'b0;
      r_rtz       <= 1'b0;
      r_left      <= 1'b0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid_i && r_in_ready) begin
            r_in_ready <= 1'b0;
            r_sign     <= w_sign;
            r_signed   <= signed_i;
            r_rtz      <= rtz_i;
            r_mag      <= MAG_W'(w_mant);
            r_g        <= 1'b0;
            r_s        <= 1'b0;
            r_left     <= 1'b0;
            r_cnt      <= '0;
            if (w_exp >= EXP_SAT) begin
              // NaN, Inf and finite values too large for any INT_W result
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_flags     <= 2'b10;
              if (w_sign && !w_is_nan) begin
                r_result <= signed_i ? SMIN : '0;
              end else begin
                r_result <= signed_i ? SMAX : UMAX;
              end
            end else if (w_exp == 8'd0) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_result    <= '0;
              r_flags     <= {1'b0, (w_frac != 7'd0)};
            end else if (w_exp < EXP_MIN) begin
              r_mag   <= '0;
              r_s     <= 1'b1;
              r_state <= S_ROUND;
            end else if (w_exp == EXP_E7) begin
              r_state <= S_ROUND;
            end else if (w_exp < EXP_E7) begin
              r_cnt   <= CNT_W'(EXP_E7 - w_exp);
              r_state <= S_SHIFT;
            end else begin
              r_cnt   <= CNT_W'(w_exp - EXP_E7);
              r_left  <= 1'b1;
              r_state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
`ifdef BF16_CVT_FAST_SHIFT_EN
          if (r_left) begin
            r_mag <= r_mag << r_cnt;
          end else begin
            r_mag <= MAG_W'(w_ext[15:8]);
            r_g   <= w_ext[7];
            r_s   <= |w_ext[6:0];
          end
          r_cnt   <= '0;
          r_state <= S_ROUND;
`else
          if (r_left) begin
            r_mag <= r_mag << 1;
          end else begin
            r_mag <= r_mag >> 1;
            r_g   <= r_mag[0];
            r_s   <= r_s | r_g;
          end
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_ROUND;
          end
`endif
        end
        S_ROUND: begin
          r_result    <= w_rnd_res;
          r_flags     <= w_rnd_flg;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready_i) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bf16_to_int_seq.sv
// Scoreboard bench for bf16_to_int_seq: directed vectors, decoupled driver and monitor.
module tb_bf16_to_int_seq;
  localparam int unsigned INT_W = 32;
`ifdef BF16_CVT_FAST_SHIFT_EN
  localparam int LAT_E0  = 3;
  localparam int LAT_E31 = 3;
`else
  localparam int LAT_E0  = 9;
  localparam int LAT_E31 = 26;
`endif

  typedef struct {
    logic [31:0] res;
    logic [1:0]  flg;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      op_a = 16'h0000;
  logic             sgn = 1'b0;
  logic             rtz = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [INT_W-1:0] result;
  logic [1:0]       flags;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  bf16_to_int_seq #(.INT_W(INT_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .op_a_i      (op_a),
    .signed_i    (sgn),
    .rtz_i       (rtz),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .flags_o     (flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Wait for the converter to go idle, present one operand, and record its expected response
  task automatic issue(input string name, input logic [15:0] op, input logic s, input logic z,
                       input logic [31:0] res, input logic [1:0] flg, input int lat);
    exp_t e;
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s: in_ready timeout got 0 expected 1", name);
    end else begin
      op_a = op;
      sgn = s;
      rtz = z;
      in_valid = 1'b1;
      e.res = res; e.flg = flg; e.lat = lat; e.acc = cyc; e.name = name;
      sb.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: pending results got %0d expected 0", name, sb.size());
    end
  endtask

  // Monitor: compare whenever a result is handed off
  initial begin
    exp_t e;
    bit   seen;
    int   first;
    seen = 1'b0;
    first = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        seen = 1'b0;
      end else if (out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          first = cyc;
        end
        if (out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %h expected none", result);
          end else begin
            e = sb.pop_front();
            check({e.name, "_result"}, result, e.res);
            check({e.name, "_flags"}, 32'(flags), 32'(e.flg));
            if (e.lat != 0) check({e.name, "_latency"}, 32'(first - e.acc), 32'(e.lat));
          end
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_flags", 32'(flags), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    issue("p1_5_rne",   16'h3FC0, 1'b1, 1'b0, 32'h0000_0002, 2'b01, LAT_E0);
    issue("p1_5_rtz",   16'h3FC0, 1'b1, 1'b1, 32'h0000_0001, 2'b01, LAT_E0);
    issue("m123",       16'hC2F6, 1'b1, 1'b0, 32'hFFFF_FF85, 2'b00, 3);
    issue("p0_5_tie",   16'h3F00, 1'b1, 1'b0, 32'h0000_0000, 2'b01, 0);
    issue("pinf_s",     16'h7F80, 1'b1, 1'b0, 32'h7FFF_FFFF, 2'b10, 1);
    issue("nan_u",      16'h7FC0, 1'b0, 1'b0, 32'hFFFF_FFFF, 2'b10, 1);
    issue("minf_u",     16'hFF80, 1'b0, 1'b0, 32'h0000_0000, 2'b10, 1);
    issue("p2e31_s",    16'h4F00, 1'b1, 1'b0, 32'h7FFF_FFFF, 2'b10, LAT_E31);
    issue("m2e31_s",    16'hCF00, 1'b1, 1'b0, 32'h8000_0000, 2'b00, 0);
    issue("p2e31_u",    16'h4F00, 1'b0, 1'b0, 32'h8000_0000, 2'b00, 0);
    issue("m1_u",       16'hBF80, 1'b0, 1'b0, 32'h0000_0000, 2'b10, 0);
    issue("subnorm_s",  16'h0001, 1'b1, 1'b0, 32'h0000_0000, 2'b01, 1);
    issue("zero",       16'h0000, 1'b1, 1'b0, 32'h0000_0000, 2'b00, 1);
    issue("p2_5_tie",   16'h4020, 1'b1, 1'b0, 32'h0000_0002, 2'b01, 0);
    issue("p3_5_tie",   16'h4060, 1'b1, 1'b0, 32'h0000_0004, 2'b01, 0);
    issue("p128_e7",    16'h4300, 1'b1, 1'b0, 32'h0000_0080, 2'b00, 2);
    issue("m1_5_s",     16'hBFC0, 1'b1, 1'b0, 32'hFFFF_FFFE, 2'b01, 0);
    issue("m0_5_u",     16'hBF00, 1'b0, 1'b0, 32'h0000_0000, 2'b01, 0);
    issue("p0_25",      16'h3E80, 1'b1, 1'b0, 32'h0000_0000, 2'b01, 2);
    issue("p2e64_s",    16'h5F80, 1'b1, 1'b0, 32'h7FFF_FFFF, 2'b10, 1);
    issue("p2e32_u",    16'h4F80, 1'b0, 1'b0, 32'hFFFF_FFFF, 2'b10, 1);
    issue("big_u",      16'h4F7F, 1'b0, 1'b0, 32'hFF00_0000, 2'b00, 0);
    issue("big_s",      16'h4EFF, 1'b1, 1'b0, 32'h7F80_0000, 2'b00, 0);
    wait_empty("vectors_drain");

    // Back-pressure: result must hold while the consumer stalls
    out_ready = 1'b0;
    issue("stall_m123", 16'hC2F6, 1'b1, 1'b0, 32'hFFFF_FF85, 2'b00, 3);
    n = 0;
    #1;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("stall_valid_seen", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("stall_result_hold", result, 32'hFFFF_FF85);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    out_ready = 1'b1;
    wait_empty("stall_drain");

    // Reset in the middle of a long serial shift discards the operation
    issue("rst_victim", 16'h4F00, 1'b1, 1'b0, 32'h7FFF_FFFF, 2'b10, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    issue("after_rst_p3", 16'h4040, 1'b1, 1'b0, 32'h0000_0003, 2'b00, 0);
    wait_empty("final_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
